// File: rtl/distributor_1s4.sv
// Registered 1-to-4 stream distributor: one input word is steered by in_sel into one of
// four single-word lane registers, each drained by its own valid/ready handshake.
module distributor_1s4 #(
  parameter int DATA_W = 2,
  parameter int CNT_W  = 8
) (
  input  logic              sys_clk,
  input  logic              sys_rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        in_sel,
  input  logic [DATA_W-1:0] in_data,
  output logic [3:0]        out_valid,
  input  logic [3:0]        out_ready,
  output logic [DATA_W-1:0] out_data_0,
  output logic [DATA_W-1:0] out_data_1,
  output logic [DATA_W-1:0] out_data_2,
  output logic [DATA_W-1:0] out_data_3,
  output logic [CNT_W-1:0]  xfer_cnt
);

  logic [3:0]        full_reg;
  logic [3:0]        full_next;
  logic [DATA_W-1:0] data_reg  [4];
  logic [DATA_W-1:0] data_next [4];
  logic [3:0]        load;
  logic [CNT_W-1:0]  cnt_reg;
  logic [CNT_W-1:0]  cnt_next;
  logic              accept;

  // A lane can take a word when empty, or when its current word leaves this same edge.
  assign in_ready = ~full_reg[in_sel] | out_ready[in_sel];
  assign accept   = in_valid & in_ready;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      assign load[gi] = accept & (in_sel == 2'(gi));

      // Refill wins over drain, so a simultaneous drain+refill keeps the lane full.
      always_comb begin
        full_next[gi] = full_reg[gi];
        data_next[gi] = data_reg[gi];
        if (load[gi]) begin
          full_next[gi] = 1'b1;
          data_next[gi] = in_data;
        end else if (out_ready[gi]) begin
          full_next[gi] = 1'b0;
        end
      end

      always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
          full_reg[gi] <= 1'b0;
          data_reg[gi] <= '0;
        end else begin
          full_reg[gi] <= full_next[gi];
          data_reg[gi] <= data_next[gi];
        end
      end
    end
  endgenerate

  assign cnt_next = accept ? cnt_reg + 1'b1 : cnt_reg;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      cnt_reg <= '0;
    end else begin
      cnt_reg <= cnt_next;
    end
  end

  assign out_valid  = full_reg;
  assign out_data_0 = data_reg[0];
  assign out_data_1 = data_reg[1];
  assign out_data_2 = data_reg[2];
  assign out_data_3 = data_reg[3];
  assign xfer_cnt   = cnt_reg;

endmodule
